// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage widths, reset constants and fetch state encoding
package cpu_pkg;

    localparam int XLEN = 19;
    localparam logic [XLEN-1:0] RESET_PC  = 19'h00000;
    localparam logic [XLEN-1:0] NOP_INSTR = 19'h00000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry pc+instr holding register used while ID is stalled
module if_skid_buf
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC update, imem reads, IF/ID register, redirects
module if_fetch_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pcwrite,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] req_pc;
    logic            redirect_q;
    logic            accept;
    logic            outstanding;
    logic            ifid_free;
    logic            rsp_load;
    logic            skid_load;
    logic            skid_unload;
    logic            flush;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    assign imem_addr = pc;
    assign ifid_free = !ifid_valid || !id_stall;

    always_comb begin
        state_n     = state;
        imem_req    = 1'b0;
        pcwrite     = 1'b0;
        next_pc     = RESET_PC;
        accept      = 1'b0;
        outstanding = 1'b0;
        rsp_load    = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        flush       = 1'b0;
        if (reset) begin
            // The cycle after a redirect the PC register only just took the
            // new target, so no request is issued from it yet.
            imem_req = (state == FETCH) && !redirect_q;
            accept   = imem_req && imem_gnt;
            case (state)
                FETCH: begin
                    if (accept) begin
                        pcwrite = 1'b1;
                        next_pc = pc + XLEN'(1);
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (ifid_free) begin
                            rsp_load = 1'b1;
                            state_n  = FETCH;
                        end else begin
                            skid_load = 1'b1;
                            state_n   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!id_stall && skid_valid) begin
                        skid_unload = 1'b1;
                        state_n     = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
            if (redirect) begin
                // A response arriving in the same cycle as the redirect closes
                // the outstanding read, so it is dropped here rather than in DRAIN.
                outstanding = ((state == WAIT || state == DRAIN) && !imem_rvalid) ||
                              (state == FETCH && accept);
                flush       = 1'b1;
                pcwrite     = 1'b1;
                next_pc     = redirect_pc;
                rsp_load    = 1'b0;
                skid_load   = 1'b0;
                skid_unload = 1'b0;
                state_n     = outstanding ? DRAIN : FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            redirect_q <= 1'b0;
            req_pc     <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else begin
            state      <= state_n;
            redirect_q <= redirect;
            if (accept) req_pc <= pc;
            if (flush) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (rsp_load) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= req_pc;
                ifid_instr <= imem_rdata;
            end else if (skid_unload) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= skid_pc;
                ifid_instr <= skid_instr;
            end else if (ifid_valid && !id_stall) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end
        end
    end

    if_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (flush),
        .load_pc    (req_pc),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [18:0]     pc;
    logic            pcwrite;
    logic [18:0]     next_pc;
    logic            imem_req;
    logic [18:0]     imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [18:0]     imem_rdata = '0;
    logic            id_stall = 1'b0;
    logic            redirect = 1'b0;
    logic [18:0]     redirect_pc = '0;
    logic            ifid_valid;
    logic [18:0]     ifid_pc;
    logic [18:0]     ifid_instr;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pcwrite     (pcwrite),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    always #5 clk = ~clk;

    // PC register owned by the surrounding pipeline
    always @(posedge clk or negedge reset) begin
        if (!reset)       pc <= 19'h00000;
        else if (pcwrite) pc <= next_pc;
    end

    task automatic drive(input logic g, input logic rv, input logic [18:0] rd,
                         input logic st, input logic rdr, input logic [18:0] rp);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        id_stall    = st;
        redirect    = rdr;
        redirect_pc = rp;
    endtask

    task automatic do_reset();
        drive(0, 0, 19'h0, 0, 0, 19'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1, 1, 19'h07777, 1, 1, 19'h00123);
        #1;
        n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pcwrite: got %h expected 0", pcwrite); end
        n_checks++; if (next_pc !== 19'h00000) begin n_fail++; $display("FAIL rst_next_pc: got %h expected 00000", next_pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %h expected 0", imem_req); end
        @(negedge clk); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ifid_valid: got %h expected 0", ifid_valid); end
        n_checks++; if (ifid_pc !== 19'h00000) begin n_fail++; $display("FAIL rst_ifid_pc: got %h expected 00000", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h00000) begin n_fail++; $display("FAIL rst_ifid_instr: got %h expected 00000", ifid_instr); end
        do_reset();
    endtask

    task automatic test_single();
        drive(1, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %h expected 1", imem_req); end
        n_checks++; if (imem_addr !== 19'h00000) begin n_fail++; $display("FAIL single_addr: got %h expected 00000", imem_addr); end
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL single_pcwrite: got %h expected 1", pcwrite); end
        n_checks++; if (next_pc !== 19'h00001) begin n_fail++; $display("FAIL single_next_pc: got %h expected 00001", next_pc); end
        @(negedge clk);
        drive(0, 1, 19'h01234, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL single_wait_req: got %h expected 0", imem_req); end
        n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL single_wait_pcwrite: got %h expected 0", pcwrite); end
        @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %h expected 1", ifid_valid); end
        n_checks++; if (ifid_pc !== 19'h00000) begin n_fail++; $display("FAIL single_ifid_pc: got %h expected 00000", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h01234) begin n_fail++; $display("FAIL single_instr: got %h expected 01234", ifid_instr); end
        n_checks++; if (imem_addr !== 19'h00001) begin n_fail++; $display("FAIL single_next_addr: got %h expected 00001", imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got %h expected 0", ifid_valid); end
        n_checks++; if (ifid_instr !== 19'h00000) begin n_fail++; $display("FAIL single_nop: got %h expected 00000", ifid_instr); end
        do_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 19'h0, 0, 0, 19'h0); #1;
            n_checks++; if (imem_addr !== 19'(i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", i, imem_addr, 19'(i)); end
            n_checks++; if (next_pc !== 19'(i + 1)) begin n_fail++; $display("FAIL seq_next_pc%0d: got %h expected %h", i, next_pc, 19'(i + 1)); end
            if (i > 0) begin
                n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %h expected 1", i, ifid_valid); end
                n_checks++; if (ifid_pc !== 19'(i - 1)) begin n_fail++; $display("FAIL seq_ifid_pc%0d: got %h expected %h", i, ifid_pc, 19'(i - 1)); end
                n_checks++; if (ifid_instr !== 19'(32'hA0 + i - 1)) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", i, ifid_instr, 19'(32'hA0 + i - 1)); end
            end
            @(negedge clk);
            drive(0, 1, 19'(32'hA0 + i), 0, 0, 19'h0); #1;
            n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_valid%0d: got %h expected 0", i, ifid_valid); end
            @(negedge clk);
        end
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_pc !== 19'h00003) begin n_fail++; $display("FAIL seq_last_pc: got %h expected 00003", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h000A3) begin n_fail++; $display("FAIL seq_last_instr: got %h expected 000a3", ifid_instr); end
        do_reset();
    endtask

    task automatic test_stall();
        drive(1, 0, 19'h0, 0, 0, 19'h0);     @(negedge clk);
        drive(0, 1, 19'h000C0, 0, 0, 19'h0); @(negedge clk);
        drive(1, 0, 19'h0, 0, 0, 19'h0);     @(negedge clk);
        drive(0, 1, 19'h000C1, 0, 0, 19'h0); @(negedge clk);
        drive(1, 0, 19'h0, 1, 0, 19'h0); #1;
        n_checks++; if (ifid_pc !== 19'h00001) begin n_fail++; $display("FAIL stall_pre_pc: got %h expected 00001", ifid_pc); end
        n_checks++; if (imem_addr !== 19'h00002) begin n_fail++; $display("FAIL stall_addr: got %h expected 00002", imem_addr); end
        @(negedge clk);
        drive(0, 1, 19'h000C2, 1, 0, 19'h0); #1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 19'h0, 1, 0, 19'h0); #1;
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold_req%0d: got %h expected 0", k, imem_req); end
            n_checks++; if (ifid_pc !== 19'h00001) begin n_fail++; $display("FAIL stall_hold_pc%0d: got %h expected 00001", k, ifid_pc); end
            n_checks++; if (ifid_instr !== 19'h000C1) begin n_fail++; $display("FAIL stall_hold_instr%0d: got %h expected 000c1", k, ifid_instr); end
            @(negedge clk);
        end
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_release_req: got %h expected 0", imem_req); end
        @(negedge clk); #1;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %h expected 1", ifid_valid); end
        n_checks++; if (ifid_pc !== 19'h00002) begin n_fail++; $display("FAIL stall_out_pc: got %h expected 00002", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h000C2) begin n_fail++; $display("FAIL stall_out_instr: got %h expected 000c2", ifid_instr); end
        n_checks++; if (imem_addr !== 19'h00003) begin n_fail++; $display("FAIL stall_next_addr: got %h expected 00003", imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup: got %h expected 0", ifid_valid); end
        do_reset();
    endtask

    task automatic test_redirect();
        drive(1, 0, 19'h0, 0, 0, 19'h0);     @(negedge clk);
        drive(0, 1, 19'h000D0, 0, 0, 19'h0); @(negedge clk);
        drive(1, 0, 19'h0, 1, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre_valid: got %h expected 1", ifid_valid); end
        @(negedge clk);
        drive(0, 0, 19'h0, 1, 1, 19'h00100); #1;
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL redir_pcwrite: got %h expected 1", pcwrite); end
        n_checks++; if (next_pc !== 19'h00100) begin n_fail++; $display("FAIL redir_next_pc: got %h expected 00100", next_pc); end
        @(negedge clk);
        drive(0, 0, 19'h0, 1, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %h expected 0", ifid_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_drain_req: got %h expected 0", imem_req); end
        @(negedge clk);
        drive(0, 1, 19'h00BAD, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_stale_req: got %h expected 0", imem_req); end
        @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dropped: got %h expected 0", ifid_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_new_req: got %h expected 1", imem_req); end
        n_checks++; if (imem_addr !== 19'h00100) begin n_fail++; $display("FAIL redir_new_addr: got %h expected 00100", imem_addr); end
        @(negedge clk);
        drive(1, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (next_pc !== 19'h00101) begin n_fail++; $display("FAIL redir_inc: got %h expected 00101", next_pc); end
        @(negedge clk);
        drive(0, 1, 19'h00ABC, 0, 0, 19'h0); @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_pc !== 19'h00100) begin n_fail++; $display("FAIL redir_ifid_pc: got %h expected 00100", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h00ABC) begin n_fail++; $display("FAIL redir_ifid_instr: got %h expected 00abc", ifid_instr); end
        do_reset();
    endtask

    task automatic test_wrap();
        drive(0, 0, 19'h0, 0, 1, 19'h7FFFF); #1;
        n_checks++; if (next_pc !== 19'h7FFFF) begin n_fail++; $display("FAIL wrap_redir: got %h expected 7ffff", next_pc); end
        @(negedge clk);
        drive(1, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_forced_req: got %h expected 0", imem_req); end
        n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL wrap_no_accept: got %h expected 0", pcwrite); end
        @(negedge clk); #1;
        n_checks++; if (imem_addr !== 19'h7FFFF) begin n_fail++; $display("FAIL wrap_addr: got %h expected 7ffff", imem_addr); end
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL wrap_pcwrite: got %h expected 1", pcwrite); end
        n_checks++; if (next_pc !== 19'h00000) begin n_fail++; $display("FAIL wrap_next_pc: got %h expected 00000", next_pc); end
        @(negedge clk);
        drive(0, 1, 19'h00055, 0, 0, 19'h0); @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_pc !== 19'h7FFFF) begin n_fail++; $display("FAIL wrap_ifid_pc: got %h expected 7ffff", ifid_pc); end
        n_checks++; if (imem_addr !== 19'h00000) begin n_fail++; $display("FAIL wrap_pc_reg: got %h expected 00000", imem_addr); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 19'h0, 0, 0, 19'h0);     @(negedge clk);
        drive(0, 1, 19'h000E0, 0, 0, 19'h0); @(negedge clk);
        drive(1, 0, 19'h0, 1, 0, 19'h0);     @(negedge clk);
        drive(0, 0, 19'h0, 1, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %h expected 1", ifid_valid); end
        reset = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %h expected 0", ifid_valid); end
        n_checks++; if (ifid_pc !== 19'h00000) begin n_fail++; $display("FAIL mid_ifid_pc: got %h expected 00000", ifid_pc); end
        n_checks++; if (ifid_instr !== 19'h00000) begin n_fail++; $display("FAIL mid_instr: got %h expected 00000", ifid_instr); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %h expected 0", imem_req); end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 19'h00BAD, 0, 0, 19'h0); #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_restart_req: got %h expected 1", imem_req); end
        @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL mid_late_ignored: got %h expected 0", ifid_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_still_fetch: got %h expected 1", imem_req); end
        @(negedge clk);
        drive(1, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (imem_addr !== 19'h00000) begin n_fail++; $display("FAIL mid_addr: got %h expected 00000", imem_addr); end
        n_checks++; if (next_pc !== 19'h00001) begin n_fail++; $display("FAIL mid_next_pc: got %h expected 00001", next_pc); end
        @(negedge clk);
        drive(0, 1, 19'h000F0, 0, 0, 19'h0); @(negedge clk);
        drive(0, 0, 19'h0, 0, 0, 19'h0); #1;
        n_checks++; if (ifid_instr !== 19'h000F0) begin n_fail++; $display("FAIL mid_refetch_instr: got %h expected 000f0", ifid_instr); end
        n_checks++; if (ifid_pc !== 19'h00000) begin n_fail++; $display("FAIL mid_refetch_pc: got %h expected 00000", ifid_pc); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
